wb_arbiter: RTL

//  Shares the single exe->issue/ROB writeback bus among UNITS execution units (ALU, BR, MUL/DIV, MEM).

---
 rtl/wb_arbiter_pkg.sv | 41 ++++
 rtl/wb_arbiter_rr.sv | 43 ++++
 rtl/wb_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared execution-side writeback definitions: unit indices, exception codes,
// polarity constants and the default-width writeback record.
package wb_arbiter_pkg;

    localparam int unsigned EXE_UNITS     = 4;
    localparam int unsigned DATA_WIDTH    = 32;
    localparam int unsigned ROB_DEPTH_DEF = 32;
    localparam int unsigned REG_ADDR_W    = 5;
    localparam int unsigned EXP_CODE_W    = 4;

    // Active-low strobes throughout the exe interfaces
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    typedef enum logic [1:0] {
        UNIT_IDX_ALU = 2'd0,
        UNIT_IDX_BR  = 2'd1,
        UNIT_IDX_MDU = 2'd2,
        UNIT_IDX_MEM = 2'd3
    } unit_idx_t;

    typedef enum logic [EXP_CODE_W-1:0] {
        EXP_NONE          = 4'd0,
        EXP_I_MISS_ALIGN  = 4'd1,
        EXP_I_FAULT       = 4'd2,
        EXP_ILLEGAL_INST  = 4'd3,
        EXP_LD_MISS_ALIGN = 4'd4,
        EXP_ST_MISS_ALIGN = 4'd5
    } exp_code_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0]            rd;
        logic [DATA_WIDTH-1:0]            data;
        logic [$clog2(ROB_DEPTH_DEF)-1:0] rob_id;
        logic                             exp_;
        logic [EXP_CODE_W-1:0]            exp_code;
        logic                             pred_miss_;
        logic                             jump_miss_;
    } wb_req_t;

endpackage

// File: rtl/wb_arbiter_rr.sv
// Round-robin arbiter: one-hot grant starting the scan at a pointer that moves
// past each winner when updates are enabled. Reused for issue-side select.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] winner;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        gnt    = '0;
        winner = ptr;
        idx    = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = PW'((32'(ptr) + i) % N);
            if (!found && req[idx]) begin
                found    = 1'b1;
                winner   = idx;
                gnt[idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (en && found) begin
            ptr <= (winner == PW'(N - 1)) ? '0 : winner + PW'(1);
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback bus arbiter: picks one execution unit per cycle, drives the early
// wakeup combinationally and the full writeback payload one cycle later.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned UNITS     = EXE_UNITS,
    parameter int unsigned DATA      = DATA_WIDTH,
    parameter int unsigned ROB_DEPTH = ROB_DEPTH_DEF,
    localparam int unsigned ROB      = $clog2(ROB_DEPTH),
    localparam int unsigned RW       = REG_ADDR_W,
    localparam int unsigned EW       = EXP_CODE_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush_,
    input  logic [UNITS-1:0]      req_e_,
    input  logic [UNITS*RW-1:0]   req_rd,
    input  logic [UNITS*DATA-1:0] req_data,
    input  logic [UNITS*ROB-1:0]  req_rob_id,
    input  logic [UNITS-1:0]      req_exp_,
    input  logic [UNITS*EW-1:0]   req_exp_code,
    input  logic [UNITS-1:0]      req_pred_miss_,
    input  logic [UNITS-1:0]      req_jump_miss_,
    output logic [UNITS-1:0]      gnt,
    output logic                  pre_wb_e_,
    output logic [RW-1:0]         pre_wb_rd,
    output logic                  wb_e_,
    output logic [RW-1:0]         wb_rd,
    output logic [DATA-1:0]       wb_data,
    output logic [ROB-1:0]        wb_rob_id,
    output logic                  wb_exp_,
    output logic [EW-1:0]         wb_exp_code,
    output logic                  wb_pred_miss_,
    output logic                  wb_jump_miss_,
    output logic [UNITS-1:0]      exe_busy
);

    typedef struct packed {
        logic [RW-1:0]   rd;
        logic [DATA-1:0] data;
        logic [ROB-1:0]  rob_id;
        logic            exp_;
        logic [EW-1:0]   exp_code;
        logic            pred_miss_;
        logic            jump_miss_;
    } wb_pl_t;

    logic             arb_en;
    logic [UNITS-1:0] req_act;
    wb_pl_t           sel;
    wb_pl_t           wb_q;
    logic             wb_e_q;

    // Reset and flush both hide requests, so no grant and no pointer movement
    assign arb_en  = !reset && flush_;
    assign req_act = arb_en ? ~req_e_ : '0;

    rr_arbiter #(.N(UNITS)) u_rr (
        .clk   (clk),
        .reset (reset),
        .en    (arb_en),
        .req   (req_act),
        .gnt   (gnt)
    );

    always_comb begin
        sel = '0;
        for (int unsigned u = 0; u < UNITS; u++) begin
            if (gnt[u]) begin
                sel.rd         = req_rd[u*RW +: RW];
                sel.data       = req_data[u*DATA +: DATA];
                sel.rob_id     = req_rob_id[u*ROB +: ROB];
                sel.exp_       = req_exp_[u];
                sel.exp_code   = req_exp_code[u*EW +: EW];
                sel.pred_miss_ = req_pred_miss_[u];
                sel.jump_miss_ = req_jump_miss_[u];
            end
        end
    end

    assign pre_wb_e_ = (|gnt) ? ENABLE_ : DISABLE_;
    assign pre_wb_rd = sel.rd;
    assign exe_busy  = arb_en ? (~req_e_ & ~gnt) : '0;

    // Payload holds while idle; only the strobe drops
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_e_q <= DISABLE_;
            wb_q   <= '0;
            wb_q.exp_       <= DISABLE_;
            wb_q.pred_miss_ <= DISABLE_;
            wb_q.jump_miss_ <= DISABLE_;
        end else if (|gnt) begin
            wb_e_q <= ENABLE_;
            wb_q   <= sel;
        end else begin
            wb_e_q <= DISABLE_;
        end
    end

    assign wb_e_         = flush_ ? wb_e_q : DISABLE_;
    assign wb_rd         = wb_q.rd;
    assign wb_data       = wb_q.data;
    assign wb_rob_id     = wb_q.rob_id;
    assign wb_exp_       = wb_q.exp_;
    assign wb_exp_code   = wb_q.exp_code;
    assign wb_pred_miss_ = wb_q.pred_miss_;
    assign wb_jump_miss_ = wb_q.jump_miss_;

endmodule
